// File: rtl/stack_pointer_unit.sv
// Data/return stack pointer unit: applies per-cycle push/pop commands, tracks
// depth, and latches a sticky fault that freezes both stacks until cleared.
module stack_pointer_unit #(
  parameter int              AW      = 16,
  parameter logic [AW-1:0]   DP_BASE = 16'h1000,
  parameter logic [AW-1:0]   RP_BASE = 16'h2000,
  parameter int              STEP    = 2,
  parameter int              DDEPTH  = 64,
  parameter int              RDEPTH  = 64,
  parameter int              CW      = 7
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          rst,
  input  logic [1:0]    dp_inc,
  input  logic [1:0]    rp_inc,
  output logic [AW-1:0] dp,
  output logic [AW-1:0] rp,
  output logic [CW-1:0] dp_depth,
  output logic [CW-1:0] rp_depth,
  output logic          fault,
  output logic [3:0]    fault_flags
);

  localparam logic [AW-1:0] STEP_A = AW'(STEP);
  localparam logic [CW-1:0] DMAX   = CW'(DDEPTH);
  localparam logic [CW-1:0] RMAX   = CW'(RDEPTH);

  typedef enum logic {RUN, FAULT} state_t;

  state_t        state, state_n;
  logic [3:0]    err;
  logic [AW-1:0] dp_n, rp_n;
  logic [CW-1:0] dp_depth_n, rp_depth_n;
  logic [3:0]    flags_n;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      dp          <= DP_BASE;
      rp          <= RP_BASE;
      dp_depth    <= '0;
      rp_depth    <= '0;
      fault_flags <= '0;
    end else if (rst) begin
      state       <= RUN;
      dp          <= DP_BASE;
      rp          <= RP_BASE;
      dp_depth    <= '0;
      rp_depth    <= '0;
      fault_flags <= '0;
    end else begin
      state       <= state_n;
      dp          <= dp_n;
      rp          <= rp_n;
      dp_depth    <= dp_depth_n;
      rp_depth    <= rp_depth_n;
      fault_flags <= flags_n;
    end
  end

  // Bit order matches fault_flags: d_over, d_under, r_over, r_under.
  always_comb begin
    err    = '0;
    err[0] = (dp_inc == 2'b01) && (dp_depth == DMAX);
    err[1] = (dp_inc == 2'b10) && (dp_depth == '0);
    err[2] = (rp_inc == 2'b10) && (rp_depth == RMAX);
    err[3] = (rp_inc == 2'b01) && (rp_depth == '0);
  end

  always_comb begin
    state_n = state;
    if (state == RUN && (|err))
      state_n = FAULT;
  end

  // Any error blocks both stacks' updates in the same cycle.
  always_comb begin
    dp_n       = dp;
    rp_n       = rp;
    dp_depth_n = dp_depth;
    rp_depth_n = rp_depth;
    flags_n    = fault_flags;
    if (state == RUN) begin
      if (|err) begin
        flags_n = err;
      end else begin
        case (dp_inc)
          2'b01: begin
            dp_n       = dp + STEP_A;
            dp_depth_n = dp_depth + 1'b1;
          end
          2'b10: begin
            dp_n       = dp - STEP_A;
            dp_depth_n = dp_depth - 1'b1;
          end
          default: ;
        endcase
        case (rp_inc)
          2'b10: begin
            rp_n       = rp - STEP_A;
            rp_depth_n = rp_depth + 1'b1;
          end
          2'b01: begin
            rp_n       = rp + STEP_A;
            rp_depth_n = rp_depth - 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    fault = (state == FAULT);
  end

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Bench for stack_pointer_unit: depth-level reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_stack_pointer_unit;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  dp_inc = 2'b00;
  logic [1:0]  rp_inc = 2'b00;
  logic [15:0] dp, rp;
  logic [6:0]  dp_depth, rp_depth;
  logic        fault;
  logic [3:0]  fault_flags;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  int   m_dd = 0;
  int   m_rd = 0;
  bit   m_fault = 1'b0;
  logic [3:0] m_flags = 4'h0;

  stack_pointer_unit #(
    .AW(16), .DP_BASE(16'h1000), .RP_BASE(16'h2000), .STEP(2),
    .DDEPTH(64), .RDEPTH(64), .CW(7)
  ) dut (
    .CLK(CLK), .reset(reset), .rst(rst),
    .dp_inc(dp_inc), .rp_inc(rp_inc),
    .dp(dp), .rp(rp), .dp_depth(dp_depth), .rp_depth(rp_depth),
    .fault(fault), .fault_flags(fault_flags)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model tracks only entry counts; pointers follow from base +/- 2*depth.
  always @(posedge CLK or posedge reset) begin
    logic [3:0] e;
    if (reset || rst) begin
      m_dd = 0; m_rd = 0; m_fault = 1'b0; m_flags = 4'h0;
    end else if (!m_fault) begin
      e = 4'h0;
      if (dp_inc == 2'b01 && m_dd == 64) e[0] = 1'b1;
      if (dp_inc == 2'b10 && m_dd == 0)  e[1] = 1'b1;
      if (rp_inc == 2'b10 && m_rd == 64) e[2] = 1'b1;
      if (rp_inc == 2'b01 && m_rd == 0)  e[3] = 1'b1;
      if (e != 4'h0) begin
        m_fault = 1'b1;
        m_flags = e;
      end else begin
        if (dp_inc == 2'b01) m_dd++;
        else if (dp_inc == 2'b10) m_dd--;
        if (rp_inc == 2'b10) m_rd++;
        else if (rp_inc == 2'b01) m_rd--;
      end
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("model_dp", 32'(dp), 32'(16'(32'h1000 + 2 * m_dd)));
      chk("model_rp", 32'(rp), 32'(16'(32'h2000 - 2 * m_rd)));
      chk("model_dp_depth", 32'(dp_depth), 32'(m_dd));
      chk("model_rp_depth", 32'(rp_depth), 32'(m_rd));
      chk("model_fault", 32'(fault), 32'(m_fault));
      chk("model_flags", 32'(fault_flags), 32'(m_flags));
    end
  end

  task automatic step(input logic [1:0] d, input logic [1:0] r, input logic c);
    @(negedge CLK);
    dp_inc = d; rp_inc = r; rst = c;
    @(posedge CLK);
    #1;
    dp_inc = 2'b00; rp_inc = 2'b00; rst = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    #1 reset = 1'b0;
    cmp_en = 1'b1;
    chk("reset_dp", 32'(dp), 32'h1000);
    chk("reset_rp", 32'(rp), 32'h2000);
    chk("reset_fault", 32'({fault, fault_flags}), 32'h0);

    // data push x3 then pop
    repeat (3) step(2'b01, 2'b00, 1'b0);
    chk("push3_dp", 32'(dp), 32'h1006);
    chk("push3_depth", 32'(dp_depth), 32'd3);
    step(2'b10, 2'b00, 1'b0);
    chk("pop_dp", 32'(dp), 32'h1004);
    chk("pop_depth", 32'(dp_depth), 32'd2);
    chk("pop_fault", 32'(fault), 32'h0);

    // return push x2, then simultaneous data push / return pop
    step(2'b00, 2'b00, 1'b1);
    repeat (2) step(2'b00, 2'b10, 1'b0);
    chk("rpush_rp", 32'(rp), 32'h1FFC);
    chk("rpush_depth", 32'(rp_depth), 32'd2);
    step(2'b01, 2'b01, 1'b0);
    chk("fromr_dp", 32'(dp), 32'h1002);
    chk("fromr_rp", 32'(rp), 32'h1FFE);

    // data underflow, then frozen in FAULT
    step(2'b00, 2'b00, 1'b1);
    step(2'b10, 2'b00, 1'b0);
    chk("dunder_fault", 32'(fault), 32'h1);
    chk("dunder_flags", 32'(fault_flags), 32'h2);
    chk("dunder_dp", 32'(dp), 32'h1000);
    repeat (5) step(2'b01, 2'b00, 1'b0);
    chk("frozen_dp", 32'(dp), 32'h1000);
    chk("frozen_depth", 32'(dp_depth), 32'd0);

    // rst exits FAULT
    step(2'b00, 2'b00, 1'b1);
    chk("clear_fault", 32'({fault, fault_flags}), 32'h0);
    chk("clear_ptrs", {dp, rp}, 32'h1000_2000);

    // fill data stack, then overflow with a legal return push alongside
    repeat (64) step(2'b01, 2'b00, 1'b0);
    chk("full_dp", 32'(dp), 32'h1080);
    chk("full_depth", 32'(dp_depth), 32'd64);
    chk("full_fault", 32'(fault), 32'h0);
    step(2'b01, 2'b10, 1'b0);
    chk("dover_flags", 32'(fault_flags), 32'h1);
    chk("dover_rp", 32'(rp), 32'h2000);
    chk("dover_dp", 32'(dp), 32'h1080);

    // rst beats a simultaneous push
    step(2'b00, 2'b00, 1'b1);
    step(2'b01, 2'b00, 1'b1);
    chk("rst_prio_dp", 32'(dp), 32'h1000);
    chk("rst_prio_depth", 32'(dp_depth), 32'd0);

    // return underflow
    step(2'b00, 2'b01, 1'b0);
    chk("runder_flags", 32'(fault_flags), 32'h8);
    step(2'b00, 2'b00, 1'b1);

    // return overflow
    repeat (64) step(2'b00, 2'b10, 1'b0);
    chk("rfull_rp", 32'(rp), 32'h1F80);
    step(2'b00, 2'b10, 1'b0);
    chk("rover_flags", 32'(fault_flags), 32'h4);
    chk("rover_rp", 32'(rp), 32'h1F80);
    step(2'b00, 2'b00, 1'b1);

    // code 11 holds; then both underflows in one cycle
    step(2'b11, 2'b11, 1'b0);
    chk("hold11", 32'({fault, dp_depth, rp_depth}), 32'h0);
    step(2'b10, 2'b01, 1'b0);
    chk("dual_flags", 32'(fault_flags), 32'hA);
    step(2'b00, 2'b00, 1'b1);

    // async reset mid-cycle with depth 5
    repeat (5) step(2'b01, 2'b00, 1'b0);
    chk("pre_async_dp", 32'(dp), 32'h100A);
    #2 reset = 1'b1;
    #1;
    chk("async_dp", 32'(dp), 32'h1000);
    chk("async_depth", 32'(dp_depth), 32'd0);
    reset = 1'b0;
    step(2'b01, 2'b10, 1'b0);
    chk("post_async", {dp, rp}, 32'h1002_1FFE);

    @(negedge CLK);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_pointer_unit.md
Name: stack_pointer_unit

Overview:
- Holds the data-stack pointer (DP) and return-stack pointer (RP) for the stack processor and applies the per-cycle dp_inc/rp_inc commands issued by the control FSM.
- Sits directly downstream of the control unit. Its outputs feed the memory address mux: DP/RP select and the stack-access address.
- Tracks the depth of each stack, detects overflow and underflow, and drives a sticky fault that freezes both pointers until the next clear.

Parameters:
- AW, 16, pointer/address width in bits.
- DP_BASE, 16'h1000, DP value for an empty data stack. Data stack grows upward.
- RP_BASE, 16'h2000, RP value for an empty return stack. Return stack grows downward.
- STEP, 2, address increment per stack entry (byte-addressed 16-bit words).
- DDEPTH, 64, maximum data-stack entries.
- RDEPTH, 64, maximum return-stack entries.
- CW, 7, depth counter width. Must satisfy 2^CW > max(DDEPTH, RDEPTH).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rst  in  1  synchronous clear from the control unit (reset_state).
- dp_inc  in  2  DP command: 00 hold, 01 push (+STEP), 10 pop (-STEP), 11 hold.
- rp_inc  in  2  RP command: 00 hold, 10 push (-STEP), 01 pop (+STEP), 11 hold.
- dp  out  AW  current data-stack pointer.
- rp  out  AW  current return-stack pointer.
- dp_depth  out  CW  current data-stack entry count.
- rp_depth  out  CW  current return-stack entry count.
- fault  out  1  high while in FAULT state.
- fault_flags  out  4  sticky cause bits: [0] data overflow, [1] data underflow, [2] return overflow, [3] return underflow.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While reset is high, or on the edge where rst=1:
  - dp=DP_BASE, rp=RP_BASE
  - dp_depth=0, rp_depth=0
  - fault=0, fault_flags=0
  - state=RUN
- rst has priority over every command on the same edge.
- Outputs are registered. A command sampled on edge N is visible on dp/rp/depths right after edge N, so a memory access in the next control state sees the updated pointer.
- FSM with two states, RUN and FAULT.
- RUN, per edge:
  - Compute errors:
    - d_over = (dp_inc==01 && dp_depth==DDEPTH)
    - d_under = (dp_inc==10 && dp_depth==0)
    - r_over = (rp_inc==10 && rp_depth==RDEPTH)
    - r_under = (rp_inc==01 && rp_depth==0)
  - If any error: go to FAULT, set fault_flags to the error vector (several bits may set together), and do NOT update either pointer or depth that cycle. The update is atomic, even when the other stack's command was legal.
  - Else: DP and RP update independently and simultaneously.
    - DP push: dp+=STEP, dp_depth+=1. DP pop: dp-=STEP, dp_depth-=1.
    - RP push: rp-=STEP, rp_depth+=1. RP pop: rp+=STEP, rp_depth-=1.
  - Code 11 on either input is treated as hold and raises no error.
- FAULT:
  - fault=1. Pointers, depths and flags are frozen and all commands are ignored.
  - Exit only via rst (to RUN, cleared) or reset.
- Arithmetic is modulo 2^AW. No wrap can occur in RUN because depth limits bound the range. Base and limit combinations that wrap are a configuration error and are not checked.
- Invariants in RUN:
  - dp == DP_BASE + STEP*dp_depth
  - rp == RP_BASE - STEP*rp_depth
- Reset asserted mid-operation, including in FAULT, clears everything immediately and asynchronously.

Test Plan:
- Reset, then three cycles of dp_inc=01 -> dp=16'h1006, dp_depth=3. Then one cycle of dp_inc=10 -> dp=16'h1004, dp_depth=2, fault=0.
- From reset, rp_inc=10 twice -> rp=16'h1FFC, rp_depth=2. Then dp_inc=01 and rp_inc=01 together (fromr-style) -> dp=16'h1002, rp=16'h1FFE.
- From reset, dp_inc=10 -> fault=1, fault_flags=4'b0010, dp=16'h1000. Then 5 cycles of dp_inc=01 -> dp and dp_depth remain unchanged.
- Push data 64 times -> dp=16'h1080, dp_depth=64. 65th push together with legal rp_inc=10 -> fault_flags=4'b0001, rp unchanged at 16'h2000.
- In FAULT, pulse rst for one cycle -> fault=0, flags=0, dp=16'h1000, rp=16'h2000. Assert rst coincident with dp_inc=01 in RUN -> cleared values win.
- Assert reset asynchronously mid-cycle with dp_depth=5 -> outputs return to base values before the next clock edge.
